// File: rtl/snake_pkg.sv
// Shared types and constants for the 16x16 LED snake game.
// Game state, direction encodings and active-low 7-segment patterns.
package snake_pkg;

    typedef enum logic [2:0] {
        GS_IDLE    = 3'd0,
        GS_WAIT    = 3'd1,
        GS_CHECK   = 3'd2,
        GS_RESOLVE = 3'd3,
        GS_MOVE    = 3'd4,
        GS_OVER    = 3'd5
    } game_state_t;

    localparam logic [1:0] DIR_W = 2'b00;
    localparam logic [1:0] DIR_A = 2'b01;
    localparam logic [1:0] DIR_S = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    // segment order gfedcba, active low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/snake_game_sequencer_bcd_to_seg7.sv
// BCD digit to active-low 7-segment decoder.
// Non-BCD codes blank the digit.
module bcd_to_seg7
    import snake_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/snake_game_sequencer.sv
// Game-flow sequencer: state machine, movement tick, speed-up and
// BCD score for the snake game.
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_START = 25_000_000,
    parameter int TICK_MIN   = 5_000_000,
    parameter int TICK_STEP  = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       died,
    input  logic       ateFood,
    output logic       enable,
    output logic       moveStep,
    output logic       growStep,
    output logic       foodPlace,
    output logic       running,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    localparam logic [2:0] IDLE    = 3'(GS_IDLE);
    localparam logic [2:0] WAIT    = 3'(GS_WAIT);
    localparam logic [2:0] CHECK   = 3'(GS_CHECK);
    localparam logic [2:0] RESOLVE = 3'(GS_RESOLVE);
    localparam logic [2:0] MOVE    = 3'(GS_MOVE);
    localparam logic [2:0] OVER    = 3'(GS_OVER);

    localparam logic [24:0] P_START = 25'(TICK_START);
    localparam logic [24:0] P_MIN   = 25'(TICK_MIN);
    localparam logic [24:0] P_STEP  = 25'(TICK_STEP);

    logic [2:0]  state;
    logic [24:0] counter;
    logic [24:0] period;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic        pausedFlag;
    logic        eatLatch;
    logic        startPlace;
    logic [24:0] periodNext;

    // guarded shrink: never drops below the floor, never underflows
    assign periodNext = (period < P_MIN + P_STEP) ? P_MIN
                                                  : period - P_STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            period     <= P_START;
            tens       <= '0;
            units      <= '0;
            pausedFlag <= 1'b0;
            eatLatch   <= 1'b0;
            startPlace <= 1'b0;
        end else begin
            startPlace <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WAIT;
                        counter    <= '0;
                        startPlace <= 1'b1;
                    end
                end
                WAIT: begin
                    if (pause)
                        pausedFlag <= ~pausedFlag;
                    if (!pausedFlag) begin
                        if (counter == period - 25'd1) begin
                            counter <= '0;
                            state   <= CHECK;
                        end else begin
                            counter <= counter + 25'd1;
                        end
                    end
                end
                CHECK: state <= RESOLVE;
                RESOLVE: begin
                    eatLatch <= ateFood;
                    state    <= died ? OVER : MOVE;
                end
                MOVE: begin
                    state <= WAIT;
                    if (eatLatch) begin
                        period <= periodNext;
                        if (!(tens == 4'd9 && units == 4'd9)) begin
                            if (units == 4'd9) begin
                                units <= 4'd0;
                                tens  <= tens + 4'd1;
                            end else begin
                                units <= units + 4'd1;
                            end
                        end
                    end
                end
                OVER: state <= OVER;
                default: state <= IDLE;
            endcase
        end
    end

    assign enable    = (state == CHECK);
    assign moveStep  = (state == MOVE);
    assign growStep  = moveStep & eatLatch;
    assign foodPlace = startPlace | growStep;
    assign running   = ~pausedFlag &
                       (state == WAIT || state == CHECK ||
                        state == RESOLVE || state == MOVE);

    bcd_to_seg7 u_tens (
        .bcd (tens),
        .seg (HEX1)
    );

    bcd_to_seg7 u_units (
        .bcd (units),
        .seg (HEX0)
    );

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Randomized self-checking bench for snake_game_sequencer.
// Expected timing and score come from a step-level game model.
module tb_snake_game_sequencer;

    localparam int TS  = 6;
    localparam int TM  = 2;
    localparam int TSP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       died = 1'b0;
    logic       ateFood = 1'b0;
    logic       enable, moveStep, growStep, foodPlace, running;
    logic [6:0] HEX1, HEX0;

    int passed = 0;
    int total  = 0;
    int m_score;
    int m_period;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    snake_game_sequencer #(
        .TICK_START (TS),
        .TICK_MIN   (TM),
        .TICK_STEP  (TSP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .died      (died),
        .ateFood   (ateFood),
        .enable    (enable),
        .moveStep  (moveStep),
        .growStep  (growStep),
        .foodPlace (foodPlace),
        .running   (running),
        .HEX1      (HEX1),
        .HEX0      (HEX0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_enable(output int n);
        n = 0;
        while (enable !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (enable !== 1'b1) n = -1;
    endtask

    function automatic int next_p(int p);
        return (p - TSP < TM) ? TM : p - TSP;
    endfunction

    task automatic game_start();
        m_score  = 0;
        m_period = TS;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (foodPlace !== 1'b1)
            $display("FAIL start_food: got %b want 1", foodPlace);
        else passed++;
        total++;
        if (running !== 1'b1)
            $display("FAIL start_running: got %b want 1", running);
        else passed++;
        tick();
        total++;
        if (foodPlace !== 1'b0)
            $display("FAIL start_food_len: got %b want 0", foodPlace);
        else passed++;
    endtask

    // Called with enable observed high; leaves the bench at the next CHECK.
    task automatic test_step(input bit eat, input bit die);
        int  n;
        bit  mv;
        bit  gr;
        mv = !die;
        gr = eat && !die;
        ateFood = eat;
        died = die;
        tick();
        tick();
        ateFood = 1'b0;
        died = 1'b0;
        total++;
        if (moveStep !== mv)
            $display("FAIL moveStep: got %b want %b", moveStep, mv);
        else passed++;
        total++;
        if (growStep !== gr || foodPlace !== gr)
            $display("FAIL grow_food: got %b%b want %b%b",
                     growStep, foodPlace, gr, gr);
        else passed++;
        if (die) begin
            total++;
            if (running !== 1'b0)
                $display("FAIL over_running: got %b want 0", running);
            else passed++;
        end
        if (gr) begin
            if (m_score < 99) m_score++;
            m_period = next_p(m_period);
        end
        tick();
        total++;
        if (HEX1 !== seg_tab[m_score / 10] ||
            HEX0 !== seg_tab[m_score % 10])
            $display("FAIL hex: got %b %b want %b %b score %0d",
                     HEX1, HEX0, seg_tab[m_score / 10],
                     seg_tab[m_score % 10], m_score);
        else passed++;
        if (!die) begin
            wait_enable(n);
            total++;
            if (n != m_period)
                $display("FAIL step_gap: got %0d want %0d", n, m_period);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if ({enable, moveStep, growStep, foodPlace, running} !== 5'b0)
            $display("FAIL reset_strobes: got %b want 00000",
                     {enable, moveStep, growStep, foodPlace, running});
        else passed++;
        total++;
        if (HEX1 !== 7'b1000000 || HEX0 !== 7'b1000000)
            $display("FAIL reset_hex: got %b %b want 1000000", HEX1, HEX0);
        else passed++;
        begin
            int hits = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (enable === 1'b1 || running === 1'b1) hits++;
            end
            total++;
            if (hits != 0)
                $display("FAIL idle_hold: got %0d want 0", hits);
            else passed++;
        end
    endtask

    task automatic test_cadence();
        int n;
        game_start();
        wait_enable(n);
        total++;
        if (n != TS - 1)
            $display("FAIL first_gap: got %0d want %0d", n + 2, TS + 1);
        else passed++;
        for (int i = 0; i < 3; i++) test_step(1'b0, 1'b0);
    endtask

    task automatic test_eat();
        for (int i = 0; i < 3; i++) test_step(1'b1, 1'b0);
        total++;
        if (m_period != TM)
            $display("FAIL period_floor: got %0d want %0d", m_period, TM);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            test_step(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic test_saturate();
        while (m_score < 99) test_step(1'b1, 1'b0);
        test_step(1'b1, 1'b0);
        total++;
        if (HEX1 !== 7'b0010000 || HEX0 !== 7'b0010000)
            $display("FAIL saturate: got %b %b want 0010000", HEX1, HEX0);
        else passed++;
    endtask

    task automatic test_over();
        int hits = 0;
        test_step(1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        pause = 1'b1;
        tick();
        pause = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (enable || foodPlace || moveStep || running) hits++;
        end
        total++;
        if (hits != 0)
            $display("FAIL over_ignores_start: got %0d want 0", hits);
        else passed++;
        total++;
        if (HEX1 !== 7'b0010000 || HEX0 !== 7'b0010000)
            $display("FAIL over_score: got %b %b", HEX1, HEX0);
        else passed++;
    endtask

    task automatic test_pause();
        int n;
        int k;
        int hits = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        game_start();
        k = $urandom_range(0, 2);
        repeat (k) tick();
        pause = 1'b1;
        tick();
        pause = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (enable === 1'b1 || running === 1'b1) hits++;
        end
        total++;
        if (hits != 0)
            $display("FAIL pause_hold: got %0d want 0", hits);
        else passed++;
        pause = 1'b1;
        tick();
        pause = 1'b0;
        total++;
        if (running !== 1'b1)
            $display("FAIL resume_running: got %b want 1", running);
        else passed++;
        wait_enable(n);
        // start tick + foodPlace tick + k + pause edge all counted
        total++;
        if (n != TS - k - 2)
            $display("FAIL resume_gap: got %0d want %0d", n, TS - k - 2);
        else passed++;
        test_step(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({enable, moveStep, running} !== 3'b0)
            $display("FAIL mid_reset: got %b want 000",
                     {enable, moveStep, running});
        else passed++;
        total++;
        if (HEX1 !== 7'b1000000 || HEX0 !== 7'b0111111 + 7'b0000001)
            $display("FAIL mid_reset_hex: got %b %b", HEX1, HEX0);
        else passed++;
        game_start();
        wait_enable(n);
        total++;
        if (n != TS - 1)
            $display("FAIL mid_reset_period: got %0d want %0d",
                     n + 1, TS);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_eat();
        test_random();
        test_saturate();
        test_over();
        test_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
